// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared states, status codes and CAM geometry for cam_sched
package cam_pkg;

   localparam int CAM_DEPTH     = 32;
   localparam int CAM_AW        = 5;
   localparam int CAM_DW        = 8;
   localparam int CAM_RSVD_SLOT = 0;

   // Response codes; FULL and ERR share an encoding
   localparam logic [1:0] ST_HIT  = 2'd0;
   localparam logic [1:0] ST_MISS = 2'd1;
   localparam logic [1:0] ST_DUP  = 2'd2;
   localparam logic [1:0] ST_FULL = 2'd3;
   localparam logic [1:0] ST_ERR  = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SRCH,
      S_EVAL,
      S_WR,
      S_ERRR,
      S_RESP
   } state_t;

   // Lowest clear occupancy bit above the reserved slot; returns the reserved slot when none is free
   function automatic logic [CAM_AW-1:0] lowest_free(input logic [CAM_DEPTH-1:0] occ);
      logic [CAM_AW-1:0] slot;
      slot = CAM_AW'(CAM_RSVD_SLOT);
      for (int i = CAM_DEPTH - 1; i > CAM_RSVD_SLOT; i--) begin
         if (!occ[i]) slot = CAM_AW'(i);
      end
      return slot;
   endfunction

endpackage

// File: rtl/cam_rr_arb.sv
// rtl/cam_rr_arb.sv - round-robin arbiter with one-hot grant and encoded id
module cam_rr_arb #(
   parameter int N = 2,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_gnt_id
);

   int w_dist;
   int w_best;

   // Pick the requester closest at or after the pointer, wrapping around
   always_comb begin
      w_dist   = 0;
      w_best   = N;
      o_gnt_id = '0;
      o_gnt    = '0;
      for (int j = 0; j < N; j++) begin
         if (i_req[j]) begin
            w_dist = (j >= int'(i_ptr)) ? (j - int'(i_ptr)) : (j + N - int'(i_ptr));
            if (w_dist < w_best) begin
               w_best   = w_dist;
               o_gnt_id = IW'(j);
            end
         end
      end
      for (int j = 0; j < N; j++) begin
         o_gnt[j] = (w_best < N) && (o_gnt_id == IW'(j));
      end
   end

endmodule

// File: rtl/cam_sched.sv
// rtl/cam_sched.sv - CAM request scheduler/sequencer; optional counters under CAM_SCHED_STATS_EN
module cam_sched
   import cam_pkg::*;
#(
   parameter int N_REQ = 2,
   localparam int IDW = $clog2(N_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [N_REQ-1:0]      req_op,
   input  logic [8*N_REQ-1:0]    req_data,
   output logic                  resp_valid,
   output logic [IDW-1:0]        resp_id,
   output logic [1:0]            resp_status,
   output logic [CAM_AW-1:0]     resp_index,
   output logic                  cam_enable,
   output logic                  cam_write,
   output logic [CAM_AW-1:0]     cam_addr,
   output logic [CAM_DW-1:0]     cam_data,
   input  logic [CAM_AW-1:0]     cam_out,
   output logic                  cam_rst_n,
   output logic                  full,
   output logic [5:0]            free_count
`ifdef CAM_SCHED_STATS_EN
   ,
   output logic [15:0]           stat_hits,
   output logic [15:0]           stat_misses,
   output logic [15:0]           stat_inserts
`endif
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [N_REQ-1:0]    r_req_ready;
   logic [IDW-1:0]      r_rr_ptr;
   logic [IDW-1:0]      r_gnt_id;
   logic                r_op;
   logic [CAM_DW-1:0]   r_key;
   logic [CAM_DEPTH-1:0] r_valid;
   logic [5:0]          r_free_count;
   logic                r_full;

   logic                r_resp_valid;
   logic [IDW-1:0]      r_resp_id;
   logic [1:0]          r_resp_status;
   logic [CAM_AW-1:0]   r_resp_index;
   logic                r_cam_enable;
   logic                r_cam_write;
   logic [CAM_AW-1:0]   r_cam_addr;
   logic [CAM_DW-1:0]   r_cam_data;

   logic [N_REQ-1:0]    w_gnt;
   logic [IDW-1:0]      w_gnt_id;
   logic [CAM_DW-1:0]   w_keys [N_REQ];
   logic [CAM_DW-1:0]   w_sel_key;
   logic                w_sel_op;
   logic                w_accept;
   logic                w_grant;
   logic [CAM_AW-1:0]   w_alloc_slot;
   logic                w_set_valid;

   logic [N_REQ-1:0]    w_ready_nxt;
   logic                w_resp_valid_nxt;
   logic [1:0]          w_resp_status_nxt;
   logic [CAM_AW-1:0]   w_resp_index_nxt;
   logic                w_cam_en_nxt;
   logic                w_cam_wr_nxt;
   logic [CAM_AW-1:0]   w_cam_addr_nxt;
   logic [CAM_DW-1:0]   w_cam_data_nxt;

   cam_rr_arb #(.N(N_REQ)) u_arb (
      .i_req    (req_valid),
      .i_ptr    (r_rr_ptr),
      .o_gnt    (w_gnt),
      .o_gnt_id (w_gnt_id)
   );

   // Split the packed key bus into per-requester keys
   always_comb begin
      for (int k = 0; k < N_REQ; k++) begin
         w_keys[k] = req_data[8*k +: 8];
      end
   end

   assign w_sel_key    = w_keys[r_gnt_id];
   assign w_sel_op     = req_op[r_gnt_id];
   assign w_accept     = (r_state == S_IDLE) && (|(r_req_ready & req_valid));
   assign w_alloc_slot = lowest_free(r_valid);

   // Next state and the next value of every registered output
   always_comb begin
      w_state_nxt       = r_state;
      w_ready_nxt       = '0;
      w_grant           = 1'b0;
      w_cam_en_nxt      = 1'b0;
      w_cam_wr_nxt      = 1'b0;
      w_cam_addr_nxt    = '0;
      w_cam_data_nxt    = '0;
      w_resp_valid_nxt  = 1'b0;
      w_resp_status_nxt = ST_HIT;
      w_resp_index_nxt  = '0;
      w_set_valid       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (|r_req_ready) begin
               // A grant whose requester dropped valid is simply discarded
               if (w_accept) begin
                  if (w_sel_key == '0) begin
                     w_state_nxt = S_ERRR;
                  end else begin
                     w_state_nxt    = S_SRCH;
                     w_cam_en_nxt   = 1'b1;
                     w_cam_data_nxt = w_sel_key;
                  end
               end
            end else if (|req_valid) begin
               w_grant     = 1'b1;
               w_ready_nxt = w_gnt;
            end
         end
         S_SRCH: begin
            w_state_nxt = S_EVAL;
         end
         S_EVAL: begin
            if (!r_op) begin
               w_state_nxt       = S_RESP;
               w_resp_valid_nxt  = 1'b1;
               w_resp_status_nxt = (cam_out != '0) ? ST_HIT : ST_MISS;
               w_resp_index_nxt  = cam_out;
            end else if (cam_out != '0) begin
               w_state_nxt       = S_RESP;
               w_resp_valid_nxt  = 1'b1;
               w_resp_status_nxt = ST_DUP;
               w_resp_index_nxt  = cam_out;
            end else if (r_full) begin
               w_state_nxt       = S_RESP;
               w_resp_valid_nxt  = 1'b1;
               w_resp_status_nxt = ST_FULL;
            end else begin
               w_state_nxt    = S_WR;
               w_cam_wr_nxt   = 1'b1;
               w_cam_addr_nxt = w_alloc_slot;
               w_cam_data_nxt = r_key;
            end
         end
         S_WR: begin
            w_set_valid       = 1'b1;
            w_state_nxt       = S_RESP;
            w_resp_valid_nxt  = 1'b1;
            w_resp_status_nxt = ST_HIT;
            w_resp_index_nxt  = r_cam_addr;
         end
         S_ERRR: begin
            w_state_nxt       = S_RESP;
            w_resp_valid_nxt  = 1'b1;
            w_resp_status_nxt = ST_ERR;
         end
         S_RESP: begin
            // Granting here lets the next accept land in the cycle after RESP
            w_state_nxt = S_IDLE;
            if (|req_valid) begin
               w_grant     = 1'b1;
               w_ready_nxt = w_gnt;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State, request latches, occupancy bitmap and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_req_ready   <= '0;
         r_rr_ptr      <= '0;
         r_gnt_id      <= '0;
         r_op          <= 1'b0;
         r_key         <= '0;
         r_valid       <= '0;
         r_free_count  <= 6'(CAM_DEPTH - 1);
         r_full        <= 1'b0;
         r_resp_valid  <= 1'b0;
         r_resp_id     <= '0;
         r_resp_status <= '0;
         r_resp_index  <= '0;
         r_cam_enable  <= 1'b0;
         r_cam_write   <= 1'b0;
         r_cam_addr    <= '0;
         r_cam_data    <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_req_ready   <= w_ready_nxt;
         r_resp_valid  <= w_resp_valid_nxt;
         r_resp_id     <= w_resp_valid_nxt ? r_gnt_id : '0;
         r_resp_status <= w_resp_status_nxt;
         r_resp_index  <= w_resp_index_nxt;
         r_cam_enable  <= w_cam_en_nxt;
         r_cam_write   <= w_cam_wr_nxt;
         r_cam_addr    <= w_cam_addr_nxt;
         r_cam_data    <= w_cam_data_nxt;
         if (w_grant) begin
            r_gnt_id <= w_gnt_id;
            r_rr_ptr <= (w_gnt_id == IDW'(N_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
         end
         if (w_accept) begin
            r_op  <= w_sel_op;
            r_key <= w_sel_key;
         end
         if (w_set_valid) begin
            r_valid[r_cam_addr] <= 1'b1;
            r_free_count        <= r_free_count - 6'd1;
            r_full              <= (r_free_count == 6'd1);
         end
      end
   end

`ifdef CAM_SCHED_STATS_EN
   logic [15:0] r_stat_hits;
   logic [15:0] r_stat_misses;
   logic [15:0] r_stat_inserts;

   // Saturating response and write counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stat_hits    <= '0;
         r_stat_misses  <= '0;
         r_stat_inserts <= '0;
      end else begin
         if (w_resp_valid_nxt && (w_resp_status_nxt == ST_HIT) && (r_stat_hits != 16'hFFFF))
            r_stat_hits <= r_stat_hits + 16'd1;
         if (w_resp_valid_nxt && (w_resp_status_nxt == ST_MISS) && (r_stat_misses != 16'hFFFF))
            r_stat_misses <= r_stat_misses + 16'd1;
         if ((r_state == S_WR) && (r_stat_inserts != 16'hFFFF))
            r_stat_inserts <= r_stat_inserts + 16'd1;
      end
   end

   assign stat_hits    = r_stat_hits;
   assign stat_misses  = r_stat_misses;
   assign stat_inserts = r_stat_inserts;
`endif

   assign req_ready   = r_req_ready;
   assign resp_valid  = r_resp_valid;
   assign resp_id     = r_resp_id;
   assign resp_status = r_resp_status;
   assign resp_index  = r_resp_index;
   assign cam_enable  = r_cam_enable;
   assign cam_write   = r_cam_write;
   assign cam_addr    = r_cam_addr;
   assign cam_data    = r_cam_data;
   assign full        = r_full;
   assign free_count  = r_free_count;
   assign cam_rst_n   = ~rst;

endmodule

// File: tb/tb_cam_sched.sv
// tb/tb_cam_sched.sv - randomized self-checking bench for cam_sched with a CAM model
module tb_cam_sched;

   localparam int N = 2;
   localparam logic [1:0] E_HIT  = 2'd0;
   localparam logic [1:0] E_MISS = 2'd1;
   localparam logic [1:0] E_DUP  = 2'd2;
   localparam logic [1:0] E_FULL = 2'd3;
   localparam logic [1:0] E_ERR  = 2'd3;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_op = '0;
   logic [8*N-1:0]  req_data = '0;
   logic [N-1:0]    req_ready;
   logic            resp_valid;
   logic [0:0]      resp_id;
   logic [1:0]      resp_status;
   logic [4:0]      resp_index;
   logic            cam_enable;
   logic            cam_write;
   logic [4:0]      cam_addr;
   logic [7:0]      cam_data;
   logic [4:0]      cam_out;
   logic            cam_rst_n;
   logic            full;
   logic [5:0]      free_count;
`ifdef CAM_SCHED_STATS_EN
   logic [15:0]     stat_hits, stat_misses, stat_inserts;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   cam_sched #(.N_REQ(N)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
      .resp_valid(resp_valid), .resp_id(resp_id), .resp_status(resp_status), .resp_index(resp_index),
      .cam_enable(cam_enable), .cam_write(cam_write), .cam_addr(cam_addr), .cam_data(cam_data),
      .cam_out(cam_out), .cam_rst_n(cam_rst_n), .full(full), .free_count(free_count)
`ifdef CAM_SCHED_STATS_EN
      , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_inserts(stat_inserts)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural 32x8 CAM: highest matching index one cycle after the strobe, else 0
   logic [7:0] cam_mem [32];

   function automatic logic [4:0] cam_search(input logic [7:0] k);
      logic [4:0] h;
      h = '0;
      for (int i = 0; i < 32; i++) if (cam_mem[i] == k) h = 5'(i);
      return h;
   endfunction

   always @(posedge clk or negedge cam_rst_n) begin
      if (!cam_rst_n) begin
         for (int i = 0; i < 32; i++) cam_mem[i] <= 8'h00;
         cam_out <= '0;
      end else begin
         if (cam_write) cam_mem[cam_addr] <= cam_data;
         cam_out <= cam_enable ? cam_search(cam_data) : 5'd0;
      end
   end

   // Reference model: key table, slot count and round-robin pointer
   int model_slot [int];
   int model_count = 0;
   int model_ptr   = 0;

   function automatic void model_apply(input bit op, input logic [7:0] key,
                                       output logic [1:0] st, output logic [4:0] idx,
                                       output int lat, output int wr_lat);
      wr_lat = -1;
      lat    = 3;
      idx    = '0;
      if (key == 8'h00) begin
         st = E_ERR; lat = 2;
      end else if (!op) begin
         if (model_slot.exists(int'(key))) begin st = E_HIT; idx = 5'(model_slot[int'(key)]); end
         else st = E_MISS;
      end else if (model_slot.exists(int'(key))) begin
         st = E_DUP; idx = 5'(model_slot[int'(key)]);
      end else if (model_count == 31) begin
         st = E_FULL;
      end else begin
         model_count++;
         model_slot[int'(key)] = model_count;
         st = E_HIT; idx = 5'(model_count); lat = 4; wr_lat = 3;
      end
   endfunction

   typedef struct {
      int         granted;
      int         en_at;
      int         n_en;
      logic [7:0] en_data;
      int         wr_at;
      logic [4:0] wr_addr;
      logic [7:0] wr_data;
      int         resp_at;
      logic [1:0] st;
      logic [4:0] idx;
      int         id;
      logic [5:0] fc;
      logic       full;
   } obs_t;

   typedef struct {
      int         id;
      logic [1:0] st;
      logic [4:0] idx;
   } exp_t;

   task automatic apply_reset;
      rst = 1'b1;
      req_valid = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      model_slot.delete();
      model_count = 0;
      model_ptr   = 0;
   endtask

   // Single request: cycle offsets are counted from the cycle req_ready is seen
   task automatic transact(input int rid, input bit op, input logic [7:0] key, output obs_t o);
      o.granted = 0; o.en_at = -1; o.n_en = 0; o.en_data = '0; o.wr_at = -1; o.wr_addr = '0;
      o.wr_data = '0; o.resp_at = -1; o.st = '0; o.idx = '0; o.id = -1; o.fc = '0; o.full = 1'b0;
      req_op[rid] = op;
      req_data[8*rid +: 8] = key;
      req_valid[rid] = 1'b1;
      for (int k = 0; k < 20 && o.granted == 0; k++) begin
         @(negedge clk);
         if (req_ready[rid]) o.granted = 1;
      end
      if (o.granted == 0) begin
         req_valid[rid] = 1'b0;
         return;
      end
      model_ptr = (rid + 1) % N;
      for (int c = 1; c <= 10 && o.resp_at < 0; c++) begin
         @(negedge clk);
         if (c == 1) req_valid[rid] = 1'b0;
         if (cam_enable) begin
            o.n_en++;
            if (o.en_at < 0) begin o.en_at = c; o.en_data = cam_data; end
         end
         if (cam_write) begin o.wr_at = c; o.wr_addr = cam_addr; o.wr_data = cam_data; end
         if (resp_valid) begin
            o.resp_at = c; o.st = resp_status; o.idx = resp_index; o.id = int'(resp_id);
            o.fc = free_count; o.full = full;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
      n_checks++; if ({resp_valid, resp_status, resp_index, resp_id} !== '0) begin n_fail++; $display("FAIL reset_resp: got %b want 0", {resp_valid, resp_status, resp_index, resp_id}); end
      n_checks++; if ({cam_enable, cam_write, cam_addr, cam_data} !== '0) begin n_fail++; $display("FAIL reset_cam: got %h want 0", {cam_enable, cam_write, cam_addr, cam_data}); end
      n_checks++; if (free_count !== 6'd31) begin n_fail++; $display("FAIL reset_free_count: got %0d want 31", free_count); end
      n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
      n_checks++; if (cam_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_cam_rst_n_low: got %b want 0", cam_rst_n); end
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (cam_rst_n !== 1'b1) begin n_fail++; $display("FAIL reset_cam_rst_n_high: got %b want 1", cam_rst_n); end
      model_slot.delete(); model_count = 0; model_ptr = 0;
   endtask

   task automatic test_insert;
      obs_t o; logic [1:0] est; logic [4:0] eidx; int el, ew;
      transact(0, 1'b1, 8'h5A, o);
      model_apply(1'b1, 8'h5A, est, eidx, el, ew);
      n_checks++; if (o.resp_at != el) begin n_fail++; $display("FAIL insert_resp_at: got %0d want %0d", o.resp_at, el); end
      n_checks++; if (o.wr_at != ew || o.wr_addr !== 5'd1 || o.wr_data !== 8'h5A) begin n_fail++; $display("FAIL insert_write: at %0d addr %0d data %h want at %0d addr 1 data 5a", o.wr_at, o.wr_addr, o.wr_data, ew); end
      n_checks++; if (o.st !== est || o.idx !== eidx) begin n_fail++; $display("FAIL insert_resp: st %0d idx %0d want st %0d idx %0d", o.st, o.idx, est, eidx); end
      n_checks++; if (o.fc !== 6'(31 - model_count)) begin n_fail++; $display("FAIL insert_free_count: got %0d want %0d", o.fc, 31 - model_count); end
      n_checks++; if (o.en_at != 1 || o.en_data !== 8'h5A) begin n_fail++; $display("FAIL insert_search: at %0d data %h want at 1 data 5a", o.en_at, o.en_data); end
   endtask

   task automatic test_lookup;
      obs_t o; logic [1:0] est; logic [4:0] eidx; int el, ew, rid; logic [7:0] key;
      for (int t = 0; t < 8; t++) begin
         if (t == 0) begin key = 8'h5A; rid = 1; end
         else if (t == 1) begin key = 8'h33; rid = 0; end
         else begin key = 8'($urandom_range(1, 255)); rid = int'($urandom_range(0, 1)); end
         transact(rid, 1'b0, key, o);
         model_apply(1'b0, key, est, eidx, el, ew);
         n_checks++; if (o.resp_at != el || o.st !== est || o.idx !== eidx) begin n_fail++; $display("FAIL lookup_%0d key %h: at %0d st %0d idx %0d want at %0d st %0d idx %0d", t, key, o.resp_at, o.st, o.idx, el, est, eidx); end
         n_checks++; if (o.en_at != 1 || o.n_en != 1 || o.en_data !== key || o.wr_at != -1) begin n_fail++; $display("FAIL lookup_cam_%0d: en_at %0d n_en %0d data %h wr_at %0d want 1 1 %h -1", t, o.en_at, o.n_en, o.en_data, o.wr_at, key); end
         n_checks++; if (o.id != rid) begin n_fail++; $display("FAIL lookup_id_%0d: got %0d want %0d", t, o.id, rid); end
      end
   endtask

   task automatic test_duplicate;
      obs_t o; logic [1:0] est; logic [4:0] eidx; int el, ew;
      transact(1, 1'b1, 8'h5A, o);
      model_apply(1'b1, 8'h5A, est, eidx, el, ew);
      n_checks++; if (o.resp_at != el || o.st !== est || o.idx !== eidx) begin n_fail++; $display("FAIL dup_resp: at %0d st %0d idx %0d want at %0d st %0d idx %0d", o.resp_at, o.st, o.idx, el, est, eidx); end
      n_checks++; if (o.wr_at != -1) begin n_fail++; $display("FAIL dup_no_write: write at %0d want none", o.wr_at); end
      transact(0, 1'b1, 8'h00, o);
      model_apply(1'b1, 8'h00, est, eidx, el, ew);
      n_checks++; if (o.resp_at != el || o.st !== est || o.idx !== eidx) begin n_fail++; $display("FAIL err_resp: at %0d st %0d idx %0d want at %0d st %0d idx %0d", o.resp_at, o.st, o.idx, el, est, eidx); end
      n_checks++; if (o.n_en != 0 || o.wr_at != -1) begin n_fail++; $display("FAIL err_no_cam: n_en %0d wr_at %0d want 0 -1", o.n_en, o.wr_at); end
   endtask

   task automatic test_contention;
      exp_t q[$]; exp_t e; logic [7:0] k1; int n_resp, g, el, ew;
      logic [1:0] est; logic [4:0] eidx;
      n_resp = 0;
      k1 = 8'($urandom_range(96, 255));
      req_op   = 2'b10;
      req_data = {k1, 8'h5A};
      req_valid = 2'b11;
      for (int c = 0; c < 200 && n_resp < 6; c++) begin
         @(negedge clk);
         if (req_ready != '0) begin
            g = model_ptr;
            n_checks++; if (req_ready !== 2'(1 << g)) begin n_fail++; $display("FAIL contention_grant: got %b want %b", req_ready, 2'(1 << g)); end
            model_apply(g == 1, (g == 1) ? k1 : 8'h5A, est, eidx, el, ew);
            q.push_back('{g, est, eidx});
            model_ptr = (g + 1) % N;
         end
         if (resp_valid) begin
            n_resp++;
            if (n_resp == 6) req_valid = '0;
            n_checks++;
            if (q.size() == 0) begin
               n_fail++; $display("FAIL contention_spurious_resp: id %0d with no grant outstanding", resp_id);
            end else begin
               e = q.pop_front();
               if (int'(resp_id) != e.id || resp_status !== e.st || resp_index !== e.idx) begin
                  n_fail++; $display("FAIL contention_resp_%0d: id %0d st %0d idx %0d want id %0d st %0d idx %0d", n_resp, resp_id, resp_status, resp_index, e.id, e.st, e.idx);
               end
            end
         end
      end
      req_valid = '0;
      n_checks++; if (n_resp != 6) begin n_fail++; $display("FAIL contention_count: got %0d responses want 6", n_resp); end
      repeat (3) @(negedge clk);
      req_op = '0;
   endtask

   task automatic test_full;
      obs_t o; logic [1:0] est; logic [4:0] eidx; int el, ew, rid, j; logic [7:0] keys [31]; logic [7:0] tmp;
      apply_reset();
      for (int i = 0; i < 31; i++) keys[i] = 8'(i + 1);
      for (int i = 30; i > 0; i--) begin
         j = int'($urandom_range(0, i)); tmp = keys[i]; keys[i] = keys[j]; keys[j] = tmp;
      end
      for (int i = 0; i < 31; i++) begin
         rid = int'($urandom_range(0, 1));
         transact(rid, 1'b1, keys[i], o);
         model_apply(1'b1, keys[i], est, eidx, el, ew);
         n_checks++; if (o.st !== est || o.idx !== eidx || o.wr_addr !== eidx) begin n_fail++; $display("FAIL full_fill_%0d key %h: st %0d idx %0d addr %0d want st %0d idx %0d", i, keys[i], o.st, o.idx, o.wr_addr, est, eidx); end
         n_checks++; if (o.fc !== 6'(31 - model_count) || o.full !== (model_count == 31)) begin n_fail++; $display("FAIL full_count_%0d: fc %0d full %b want fc %0d full %0d", i, o.fc, o.full, 31 - model_count, model_count == 31); end
      end
      transact(0, 1'b1, 8'h20, o);
      model_apply(1'b1, 8'h20, est, eidx, el, ew);
      n_checks++; if (o.resp_at != el || o.st !== est || o.idx !== eidx || o.wr_at != -1) begin n_fail++; $display("FAIL full_reject: at %0d st %0d idx %0d wr_at %0d want at %0d st %0d idx %0d wr -1", o.resp_at, o.st, o.idx, o.wr_at, el, est, eidx); end
      tmp = keys[$urandom_range(0, 30)];
      transact(1, 1'b0, tmp, o);
      model_apply(1'b0, tmp, est, eidx, el, ew);
      n_checks++; if (o.st !== est || o.idx !== eidx) begin n_fail++; $display("FAIL full_lookup key %h: st %0d idx %0d want st %0d idx %0d", tmp, o.st, o.idx, est, eidx); end
      n_checks++; if (full !== 1'b1 || free_count !== 6'd0) begin n_fail++; $display("FAIL full_flag: full %b fc %0d want 1 0", full, free_count); end
   endtask

   task automatic test_reset_mid;
      obs_t o; int got, seen_wr, stray; logic [1:0] est; logic [4:0] eidx; int el, ew;
      apply_reset();
      got = 0; seen_wr = 0; stray = 0;
      req_op[0] = 1'b1; req_data[7:0] = 8'h77; req_valid[0] = 1'b1;
      for (int k = 0; k < 20 && got == 0; k++) begin @(negedge clk); if (req_ready[0]) got = 1; end
      for (int c = 1; c <= 6 && got == 1 && seen_wr == 0; c++) begin
         @(negedge clk);
         if (c == 1) req_valid[0] = 1'b0;
         if (cam_write) seen_wr = 1;
      end
      req_valid = '0;
      n_checks++; if (seen_wr != 1) begin n_fail++; $display("FAIL midrst_reach_wr: got %0d want 1", seen_wr); end
      rst = 1'b1;
      #1;
      n_checks++; if (cam_rst_n !== 1'b0) begin n_fail++; $display("FAIL midrst_cam_rst_n: got %b want 0", cam_rst_n); end
      @(negedge clk);
      if (resp_valid) stray++;
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin @(negedge clk); if (resp_valid) stray++; end
      n_checks++; if (stray != 0) begin n_fail++; $display("FAIL midrst_no_resp: got %0d responses want 0", stray); end
      n_checks++; if (free_count !== 6'd31 || full !== 1'b0) begin n_fail++; $display("FAIL midrst_bitmap: fc %0d full %b want 31 0", free_count, full); end
      model_slot.delete(); model_count = 0; model_ptr = 0;
      transact(0, 1'b0, 8'h77, o);
      model_apply(1'b0, 8'h77, est, eidx, el, ew);
      n_checks++; if (o.st !== est || o.idx !== eidx) begin n_fail++; $display("FAIL midrst_lookup: st %0d idx %0d want st %0d idx %0d", o.st, o.idx, est, eidx); end
   endtask

   initial begin
      test_reset();
      test_insert();
      test_lookup();
      test_duplicate();
      test_contention();
      test_full();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cam_sched.md
# cam_sched

Request scheduler and sequencer for the 32×8 content-addressable memory. It arbitrates round-robin among `N_REQ` requesters and turns each accepted request into the CAM command sequence:

- a lookup issues one search cycle;
- an insert issues a search followed by a conditional write.

The block owns slot allocation for the CAM through an occupancy bitmap. It sits between the requester fabric and the CAM instance and is the only driver of the CAM ports.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters (2..8).

Ports (clock and reset first):
- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input `N_REQ`: request pending, one bit per requester.
- `req_ready` output `N_REQ`: one-hot pulse; the request is accepted on the cycle where `req_valid & req_ready`.
- `req_op` input `N_REQ`: per requester, 0 = LOOKUP, 1 = INSERT.
- `req_data` input `8*N_REQ`: per-requester key; requester k uses `[8k+7:8k]`.
- `resp_valid` output 1: one-cycle response pulse; there is no backpressure.
- `resp_id` output `$clog2(N_REQ)`: index of the requester being answered.
- `resp_status` output 2: response code (see below).
- `resp_index` output 5: CAM slot for the answered request.
- `cam_enable` output 1: CAM search strobe.
- `cam_write` output 1: CAM write strobe.
- `cam_addr` output 5: CAM write address.
- `cam_data` output 8: CAM key / write data.
- `cam_out` input 5: CAM result, one cycle after the strobe. Holds the highest matching index, or 0 if there is no match.
- `cam_rst_n` output 1: `~rst`, combinational, so that the CAM clears together with this block.
- `full` output 1: no free slot remains.
- `free_count` output 6: number of free slots, range 0..31.

## Operation
- Slot 0 is reserved and never allocated, so a `cam_out` of 0 always means miss. Usable slots are 1..31.
- Key 0x00 is illegal, because cleared CAM entries hold 0x00. A request with key 0x00 gets `resp_status` = ERR and never reaches the CAM.
- `valid[31:1]` is the occupancy bitmap. The allocation target is the lowest-index clear bit.
- Arbitration is round-robin. The pointer starts at the requester after the last grant and resets to 0.
- Only one request is in flight at a time. `req_ready` may pulse only in IDLE.
- State machine:
  - **IDLE**: if any `req_valid` is set, grant the winner, latch its op, key and id. Go to ERRR if the key is 0x00, otherwise to SRCH.
  - **SRCH**: `cam_enable` = 1, `cam_data` = key. Go to EVAL.
  - **EVAL**: sample `cam_out`.
    - LOOKUP: hit → RESP with status HIT and `index` = `cam_out`; miss → RESP with status MISS and `index` = 0.
    - INSERT: hit → RESP with status DUP and `index` = `cam_out`; miss with `full` → RESP with status FULL and `index` = 0; miss otherwise → WR.
  - **WR**: `cam_write` = 1, `cam_addr` = allocated slot, `cam_data` = key. Set `valid[slot]`. Go to RESP with status HIT and `index` = slot.
    - No CAM strobe is driven in EVAL. This keeps the CAM's internal result at 0, which its write gating requires.
  - **ERRR**: go to RESP with status ERR and `index` = 0.
  - **RESP**: `resp_valid` = 1. Go to IDLE.
- Status codes: HIT = 2'd0 (lookup hit, or insert success), MISS = 2'd1, DUP = 2'd2, FULL/ERR = 2'd3.

## Timing
- The accept cycle is A.
- Lookup: CAM strobe at A+1, `resp_valid` at A+3.
- Insert:
  - success: CAM strobe at A+1, write at A+3, `resp_valid` at A+4;
  - DUP or FULL: `resp_valid` at A+3.
- Illegal key: `resp_valid` at A+2.
- Next accept is possible at the cycle after RESP.
- All outputs are registered except `cam_rst_n`.
- Reset values:
  - all `req_ready`, `resp_*`, `cam_enable`, `cam_write`, `cam_addr` and `cam_data` are 0;
  - `valid` is 0, so `free_count` is 31 and `full` is 0;
  - the round-robin pointer is 0 and the state is IDLE.
- If reset is asserted mid-operation, the transaction is aborted: no response is given and no bitmap bit is set.
- Simultaneous requests: exactly one grant per IDLE visit. A non-granted requester must hold `req_valid`.
- A request dropped before it is granted is simply not served.
- `full` updates in the cycle after WR.

## Configuration
- `CAM_SCHED_STATS_EN`: when defined, adds outputs `stat_hits`, `stat_misses` and `stat_inserts`, each 16 bits.
  - `stat_hits` and `stat_misses` count responses; `stat_inserts` counts WR cycles.
  - The counters saturate at 0xFFFF and reset to 0.
- When the macro is undefined, these ports and counters do not exist.

## Structure
- Shared package `cam_pkg` holds:
  - the state enum;
  - the status codes;
  - the constants `CAM_DEPTH` = 32, `CAM_AW` = 5, `CAM_DW` = 8 and `CAM_RSVD_SLOT` = 0.
- One sub-module, `cam_rr_arb`: a parameterised round-robin arbiter producing a one-hot grant and an encoded id.

## Test plan
- **Insert:** with requester 0, INSERT 0x5A after reset → `cam_write` at `cam_addr` 1; response HIT, `index` 1, `free_count` 30.
- **Lookup:** LOOKUP 0x5A → HIT, `index` 1, at A+3. LOOKUP 0x33 → MISS, `index` 0.
- **Duplicate:** INSERT 0x5A again → DUP, `index` 1, no `cam_write`. INSERT 0x00 → ERR at A+2, no CAM strobe.
- **Contention:** both requesters hold `req_valid` continuously → grants alternate 0,1,0,1, and `resp_id` matches each grant.
- **Full:** perform 31 distinct inserts (0x01..0x1F) → `full` = 1; the 32nd insert (0x20) → FULL, `index` 0.
- **Reset mid-operation:** assert `rst` during WR of an insert → no `resp_valid`, `free_count` 31 afterwards, `cam_rst_n` low while `rst` is high.
